// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state type and
// small decode helpers used by the load/store unit and its lane aligner.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int HALF_WIDTH = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_WAIT = 3'd1,
        RMW_READ  = 3'd2,
        RMW_WRITE = 3'd3,
        DONE_ONLY = 3'd4
    } lsu_state_t;

    // Encodings that are not a legal RV32I access (unsigned variants exist only for loads).
    function automatic logic isIllegalFunct3(input logic [2:0] funct3, input logic isStore);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return isStore;
            default:          return 1'b1;
        endcase
    endfunction

    // Access does not sit on its natural boundary.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Byte offset rounded down to the access size's boundary.
    function automatic logic [1:0] laneOffset(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return {offset[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return offset;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extracts and extends a load lane from a
// memory word, and merges a store lane into a memory word.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      i_Funct3,
    input  logic [1:0]      i_ByteOffset,
    input  logic [XLEN-1:0] i_MemWord,
    input  logic [XLEN-1:0] i_StoreData,
    output logic [XLEN-1:0] o_LoadValue,
    output logic [XLEN-1:0] o_MergedWord
);

    logic [BYTE_WIDTH-1:0] laneByte;
    logic [HALF_WIDTH-1:0] laneHalf;

    // Select the addressed byte/half (little-endian) and extend it per funct3.
    always_comb begin
        laneByte = i_MemWord[{i_ByteOffset, 3'b000} +: BYTE_WIDTH];
        laneHalf = i_MemWord[{i_ByteOffset[1], 4'b0000} +: HALF_WIDTH];
        case (i_Funct3)
            F3_B:    o_LoadValue = {{(XLEN-BYTE_WIDTH){laneByte[BYTE_WIDTH-1]}}, laneByte};
            F3_BU:   o_LoadValue = {{(XLEN-BYTE_WIDTH){1'b0}}, laneByte};
            F3_H:    o_LoadValue = {{(XLEN-HALF_WIDTH){laneHalf[HALF_WIDTH-1]}}, laneHalf};
            F3_HU:   o_LoadValue = {{(XLEN-HALF_WIDTH){1'b0}}, laneHalf};
            default: o_LoadValue = i_MemWord;
        endcase
    end

    // Overwrite only the store lane; all other bytes keep their memory value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        o_MergedWord = i_MemWord;
        case (i_Funct3)
            F3_B:    o_MergedWord[{i_ByteOffset, 3'b000} +: BYTE_WIDTH] = i_StoreData[BYTE_WIDTH-1:0];
            F3_H:    o_MergedWord[{i_ByteOffset[1], 4'b0000} +: HALF_WIDTH] = i_StoreData[HALF_WIDTH-1:0];
            default: o_MergedWord = i_StoreData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-cache port. Accepts one load/store per handshake,
// always presents word-aligned addresses to the 1-cycle-latency cache, and
// performs sub-word stores as read-modify-write.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter bit TRAP_MISALIGNED = 1'b1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_IsStore,
    input  logic [2:0]            i_Funct3,
    input  logic [ADDR_WIDTH-1:0] i_Address,
    input  logic [XLEN-1:0]       i_StoreData,
    output logic                  o_Done,
    output logic [XLEN-1:0]       o_LoadData,
    output logic                  o_Misaligned,
    output logic                  o_MemWriteEnable,
    output logic [ADDR_WIDTH-1:0] o_MemAddress,
    output logic [XLEN-1:0]       o_MemDataOut,
    input  logic [XLEN-1:0]       i_MemDataIn
);

    lsu_state_t state, nextState;

    logic [ADDR_WIDTH-1:0] addrReg;
    logic [XLEN-1:0]       storeDataReg;
    logic [2:0]            funct3Reg;
    logic [XLEN-1:0]       loadDataReg;
    logic                  doneReg;
    logic                  misalignedReg;

    logic                  accept;
    logic                  reqFault;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [2:0]            curFunct3;
    logic [XLEN-1:0]       curStoreData;
    logic [XLEN-1:0]       loadValue;
    logic [XLEN-1:0]       mergedWord;

    // Request decode: fault detection and lane-aligned byte address.
    always_comb begin
        accept   = i_Valid && o_Ready;
        reqFault = isIllegalFunct3(i_Funct3, i_IsStore)
                 || (TRAP_MISALIGNED && isMisaligned(i_Funct3, i_Address[1:0]));
        reqAddr  = {i_Address[ADDR_WIDTH-1:2], laneOffset(i_Funct3, i_Address[1:0])};
    end

    // Memory side is driven from live inputs in IDLE, from captured request otherwise.
    always_comb begin
        if (state == IDLE) begin
            curAddr      = reqAddr;
            curFunct3    = i_Funct3;
            curStoreData = i_StoreData;
        end else begin
            curAddr      = addrReg;
            curFunct3    = funct3Reg;
            curStoreData = storeDataReg;
        end
    end

    lsu_align u_align (
        .i_Funct3     (curFunct3),
        .i_ByteOffset (curAddr[1:0]),
        .i_MemWord    (i_MemDataIn),
        .i_StoreData  (curStoreData),
        .o_LoadValue  (loadValue),
        .o_MergedWord (mergedWord)
    );

    // Next-state logic and cache strobes.
    always_comb begin
        nextState        = state;
        o_MemWriteEnable = 1'b0;
        o_MemDataOut     = curStoreData;
        o_MemAddress     = {curAddr[ADDR_WIDTH-1:2], 2'b00};
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqFault)              nextState = DONE_ONLY;
                    else if (!i_IsStore)       nextState = LOAD_WAIT;
                    else if (i_Funct3 == F3_W) o_MemWriteEnable = 1'b1;
                    else                       nextState = RMW_READ;
                end
            end
            LOAD_WAIT: nextState = IDLE;
            RMW_READ: begin
                o_MemWriteEnable = 1'b1;
                o_MemDataOut     = mergedWord;
                nextState        = IDLE;
            end
            DONE_ONLY: nextState = IDLE;
            default:   nextState = IDLE;  // RMW_WRITE is never entered; recover to IDLE
        endcase
        // A reset landing mid read-modify-write must not let the write escape.
        if (i_Reset) o_MemWriteEnable = 1'b0;
    end

    // Control state and result flags; cleared by reset.
    always_ff @(posedge i_Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_Reset) begin
            state         <= IDLE;
            doneReg       <= 1'b0;
            misalignedReg <= 1'b0;
            loadDataReg   <= '0;
        end else begin
            state         <= nextState;
            doneReg       <= 1'b0;
            misalignedReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && reqFault) begin
                        doneReg       <= 1'b1;
                        misalignedReg <= 1'b1;
                    end else if (accept && i_IsStore && i_Funct3 == F3_W) begin
                        doneReg <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    loadDataReg <= loadValue;
                    doneReg     <= 1'b1;
                end
                RMW_READ: doneReg <= 1'b1;
                default: ;
            endcase
        end
    end

    // Request capture for the multi-cycle states.
    always_ff @(posedge i_Clock) begin
        // NOTE: pure datapath capture registers need no reset; they are only read after an accept loads them.
        if (accept) begin
            addrReg      <= reqAddr;
            storeDataReg <= i_StoreData;
            funct3Reg    <= i_Funct3;
        end
    end

    assign o_Ready      = (state == IDLE) && !i_Reset;
    assign o_Done       = doneReg;
    assign o_Misaligned = misalignedReg;
    assign o_LoadData   = loadDataReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 1-cycle-latency data cache and a scoreboard of expected completions.
module tb_load_store_unit;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_Valid;
    logic        o_Ready;
    logic        i_IsStore;
    logic [2:0]  i_Funct3;
    logic [31:0] i_Address;
    logic [31:0] i_StoreData;
    logic        o_Done;
    logic [31:0] o_LoadData;
    logic        o_Misaligned;
    logic        o_MemWriteEnable;
    logic [31:0] o_MemAddress;
    logic [31:0] o_MemDataOut;
    logic [31:0] i_MemDataIn;

    int vectors     = 0;
    int miscompares = 0;
    int writeCount  = 0;
    logic [31:0] lastLoad = 32'h0;

    typedef struct {
        string       tag;
        logic [31:0] loadData;
        logic        misaligned;
        int          latency;
    } exp_t;
    exp_t scoreboard[$];

    logic [31:0] mem [logic [29:0]];

    always #5 i_Clock = ~i_Clock;

    load_store_unit dut (
        .i_Clock          (i_Clock),
        .i_Reset          (i_Reset),
        .i_Valid          (i_Valid),
        .o_Ready          (o_Ready),
        .i_IsStore        (i_IsStore),
        .i_Funct3         (i_Funct3),
        .i_Address        (i_Address),
        .i_StoreData      (i_StoreData),
        .o_Done           (o_Done),
        .o_LoadData       (o_LoadData),
        .o_Misaligned     (o_Misaligned),
        .o_MemWriteEnable (o_MemWriteEnable),
        .o_MemAddress     (o_MemAddress),
        .o_MemDataOut     (o_MemDataOut),
        .i_MemDataIn      (i_MemDataIn)
    );

    // Data cache model: registered read, write on strobe.
    always @(posedge i_Clock) begin
        if (mem.exists(o_MemAddress[31:2])) i_MemDataIn <= mem[o_MemAddress[31:2]];
        else                                i_MemDataIn <= 32'h0;
        if (o_MemWriteEnable) begin
            mem[o_MemAddress[31:2]] = o_MemDataOut;
            writeCount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // o_Misaligned must be quiet whenever o_Done is low.
    always @(negedge i_Clock) begin
        if (!i_Reset && !o_Done) check("misaligned_without_done", {31'h0, o_Misaligned}, 32'h0);
    end

    // Issue one request, then wait (bounded) for its completion and check it.
    task automatic doOp(input string tag, input bit isStore, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] loadExp, input bit misExp, input int latExp,
                        input int writesExp, input bit weAtAccept);
        exp_t e, got;
        int   lat;
        int   w0;
        @(negedge i_Clock);
        i_Valid = 1'b1; i_IsStore = isStore; i_Funct3 = f3; i_Address = addr; i_StoreData = data;
        #1;
        check({tag, "_ready"}, {31'h0, o_Ready}, 32'h1);
        check({tag, "_we_accept"}, {31'h0, o_MemWriteEnable}, {31'h0, weAtAccept});
        if (!misExp) check({tag, "_mem_addr"}, o_MemAddress, {addr[31:2], 2'b00});
        e.tag        = tag;
        e.misaligned = misExp;
        e.latency    = latExp;
        e.loadData   = (!isStore && !misExp) ? loadExp : lastLoad;
        scoreboard.push_back(e);
        w0 = writeCount;
        @(negedge i_Clock);
        i_Valid = 1'b0;
        lat = 1;
        while (!o_Done && lat < 8) begin
            @(negedge i_Clock);
            lat++;
        end
        if (!o_Done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: o_Done not seen within %0d cycles", tag, lat);
            void'(scoreboard.pop_front());
        end else begin
            got = scoreboard.pop_front();
            check({got.tag, "_latency"}, lat, got.latency);
            check({got.tag, "_load_data"}, o_LoadData, got.loadData);
            check({got.tag, "_misaligned"}, {31'h0, o_Misaligned}, {31'h0, got.misaligned});
            lastLoad = got.loadData;
        end
        check({tag, "_writes"}, writeCount - w0, writesExp);
        @(negedge i_Clock);
        check({tag, "_done_pulse"}, {31'h0, o_Done}, 32'h0);
    endtask

    initial begin
        int w0;
        mem[30'h40] = 32'h8312_F4A5;   // byte address 0x100
        mem[30'h41] = 32'h0000_0000;   // byte address 0x104
        i_Reset = 1'b1; i_Valid = 1'b0; i_IsStore = 1'b0; i_Funct3 = 3'b000;
        i_Address = '0; i_StoreData = '0;
        repeat (3) @(negedge i_Clock);
        check("rst_ready", {31'h0, o_Ready}, 32'h0);
        check("rst_done", {31'h0, o_Done}, 32'h0);
        check("rst_mis", {31'h0, o_Misaligned}, 32'h0);
        check("rst_we", {31'h0, o_MemWriteEnable}, 32'h0);
        check("rst_load", o_LoadData, 32'h0);
        i_Reset = 1'b0;
        @(negedge i_Clock);
        check("post_rst_ready", {31'h0, o_Ready}, 32'h1);

        //   tag         st    f3      addr          data          loadExp       mis lat wr  we
        doOp("lb_101",   1'b0, 3'b000, 32'h101, 32'h0,         32'hFFFF_FFF4, 0, 2, 0, 0);
        doOp("lbu_101",  1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_00F4, 0, 2, 0, 0);
        doOp("lh_102",   1'b0, 3'b001, 32'h102, 32'h0,         32'hFFFF_8312, 0, 2, 0, 0);
        doOp("lhu_100",  1'b0, 3'b101, 32'h100, 32'h0,         32'h0000_F4A5, 0, 2, 0, 0);
        doOp("lw_100",   1'b0, 3'b010, 32'h100, 32'h0,         32'h8312_F4A5, 0, 2, 0, 0);
        doOp("lb_102",   1'b0, 3'b000, 32'h102, 32'h0,         32'h0000_0012, 0, 2, 0, 0);
        doOp("sb_103",   1'b1, 3'b000, 32'h103, 32'h0000_0055, 32'h0,         0, 2, 1, 0);
        check("sb_103_mem", mem[30'h40], 32'h5512_F4A5);
        doOp("lw_100b",  1'b0, 3'b010, 32'h100, 32'h0,         32'h5512_F4A5, 0, 2, 0, 0);
        doOp("sw_104",   1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         0, 1, 1, 1);
        doOp("lw_104",   1'b0, 3'b010, 32'h104, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 0);
        doOp("lw_102m",  1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         1, 1, 0, 0);
        doOp("lh_101m",  1'b0, 3'b001, 32'h101, 32'h0,         32'h0,         1, 1, 0, 0);
        doOp("sh_102",   1'b1, 3'b001, 32'h102, 32'hFFFF_1234, 32'h0,         0, 2, 1, 0);
        check("sh_102_mem", mem[30'h40], 32'h1234_F4A5);
        doOp("lh_102b",  1'b0, 3'b001, 32'h102, 32'h0,         32'h0000_1234, 0, 2, 0, 0);

        // SH aborted by reset during its read-modify-write cycle.
        @(negedge i_Clock);
        i_Valid = 1'b1; i_IsStore = 1'b1; i_Funct3 = 3'b001; i_Address = 32'h100; i_StoreData = 32'h0000_ABCD;
        #1;
        check("sh_abort_ready", {31'h0, o_Ready}, 32'h1);
        w0 = writeCount;
        @(negedge i_Clock);
        i_Valid = 1'b0;
        i_Reset = 1'b1;
        #1;
        check("sh_abort_we", {31'h0, o_MemWriteEnable}, 32'h0);
        check("sh_abort_ready_in_rst", {31'h0, o_Ready}, 32'h0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(negedge i_Clock);
        check("sh_abort_ready_after", {31'h0, o_Ready}, 32'h1);
        check("sh_abort_writes", writeCount - w0, 32'h0);
        check("sh_abort_mem", mem[30'h40], 32'h1234_F4A5);
        check("sh_abort_load_cleared", o_LoadData, 32'h0);
        lastLoad = 32'h0;
        doOp("lw_after_abort", 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_F4A5, 0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
